// File: rtl/picnic_params_pkg.sv
// Shared parameters, state encoding and hash message layout for the Picnic3 challenge derivation.
package picnic_params_pkg;

  localparam int unsigned T_ROUNDS  = 250;
  localparam int unsigned TAU       = 36;
  localparam int unsigned N_PARTIES = 16;
  localparam int unsigned DIGEST_W  = 256;
  localparam int unsigned IDX_C_W   = 8;
  localparam int unsigned IDX_P_W   = 4;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned MSG_W     = 3 * DIGEST_W;
  localparam int unsigned CHUNKS_C  = DIGEST_W / IDX_C_W;
  localparam int unsigned CHUNKS_P  = DIGEST_W / IDX_P_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HASH0,
    S_EXT_C,
    S_RHASH_C,
    S_RHASH_P,
    S_EXT_P,
    S_DONE
  } state_e;

  // Hash message: {Ch,Cv,salt} for the first hash, {digest,0,0} for a rehash
  typedef struct packed {
    logic [DIGEST_W-1:0] hi;
    logic [DIGEST_W-1:0] mid;
    logic [DIGEST_W-1:0] lo;
  } hash_msg_t;

  function automatic hash_msg_t rehash_msg(input logic [DIGEST_W-1:0] digest);
    hash_msg_t m;
    m.hi  = digest;
    m.mid = '0;
    m.lo  = '0;
    return m;
  endfunction

endpackage

// File: rtl/picnic_digest_chunker.sv
// Holds one digest and presents it MSB-first as 8-bit or 4-bit chunks, flagging the final chunk.
module picnic_digest_chunker
  import picnic_params_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_load,
  input  logic [DIGEST_W-1:0] i_digest,
  input  logic                i_shift,
  input  logic                i_nibble,
  output logic [IDX_C_W-1:0]  o_chunk_c,
  output logic                o_last_c
);

  localparam int unsigned PTR_W = 7;

  logic [DIGEST_W-1:0] r_data;
  logic [PTR_W-1:0]    r_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
      r_ptr  <= '0;
    end else if (i_load) begin
      r_data <= i_digest;
      r_ptr  <= '0;
    end else if (i_shift) begin
      r_data <= i_nibble ? (r_data << IDX_P_W) : (r_data << IDX_C_W);
      r_ptr  <= r_ptr + PTR_W'(1);
    end
  end

  // Nibble chunks are zero-extended so the top sees a single chunk bus
  assign o_chunk_c = i_nibble ? IDX_C_W'(r_data[DIGEST_W-1 -: IDX_P_W])
                              : r_data[DIGEST_W-1 -: IDX_C_W];
  assign o_last_c  = i_nibble ? (r_ptr == PTR_W'(CHUNKS_P - 1))
                              : (r_ptr == PTR_W'(CHUNKS_C - 1));

endmodule

// File: rtl/picnic_hcp_challenge.sv
// Picnic3 challenge derivation: hashes {Ch,Cv,salt}, then expands digests into TAU distinct
// round indices and TAU party indices, rehashing whenever a digest runs out.
module picnic_hcp_challenge
  import picnic_params_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     hcp_start,
  input  logic [DIGEST_W-1:0]      Ch,
  input  logic [DIGEST_W-1:0]      Cv,
  input  logic [DIGEST_W-1:0]      salt,
  output logic                     hash_start,
  output logic                     hash_mode,
  output logic [MSG_W-1:0]         hash_in,
  input  logic                     hash_done,
  input  logic [DIGEST_W-1:0]      hash_digest,
  output logic [TAU*IDX_C_W-1:0]   challenge_c,
  output logic [TAU*IDX_P_W-1:0]   challenge_p,
  output logic                     hcp_end
);

  state_e                         r_state;
  logic                           r_hash_start;
  logic                           r_hash_mode;
  hash_msg_t                      r_hash_in;
  logic [TAU-1:0][IDX_C_W-1:0]    r_list_c;
  logic [TAU-1:0][IDX_P_W-1:0]    r_list_p;
  logic                           r_hcp_end;
  logic [T_ROUNDS-1:0]            r_bitmap;
  logic [CNT_W-1:0]               r_c_cnt;
  logic [CNT_W-1:0]               r_p_cnt;
  logic [DIGEST_W-1:0]            r_digest;

  logic                           w_in_hash;
  logic                           w_load;
  logic                           w_shift;
  logic                           w_nibble;
  logic [IDX_C_W-1:0]             w_chunk;
  logic                           w_last;
  logic                           w_c_ok;

  assign w_in_hash = (r_state == S_HASH0) || (r_state == S_RHASH_C) || (r_state == S_RHASH_P);
  assign w_load    = w_in_hash && hash_done;
  assign w_shift   = (r_state == S_EXT_C) || (r_state == S_EXT_P);
  assign w_nibble  = (r_state == S_EXT_P);
  // Bitmap lookup only matters when the chunk is a legal round index
  assign w_c_ok    = (w_chunk < IDX_C_W'(T_ROUNDS)) && !r_bitmap[w_chunk];

  picnic_digest_chunker u_chunker (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_digest  (hash_digest),
    .i_shift   (w_shift),
    .i_nibble  (w_nibble),
    .o_chunk_c (w_chunk),
    .o_last_c  (w_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_hash_start <= 1'b0;
      r_hash_mode  <= 1'b0;
      r_hash_in    <= '0;
      r_list_c     <= '0;
      r_list_p     <= '0;
      r_hcp_end    <= 1'b0;
      r_bitmap     <= '0;
      r_c_cnt      <= '0;
      r_p_cnt      <= '0;
      r_digest     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (!hcp_start) begin
            r_hcp_end <= 1'b0;
          end else if (!r_hcp_end) begin
            r_state      <= S_HASH0;
            r_hash_start <= 1'b1;
            r_hash_mode  <= 1'b0;
            r_hash_in    <= '{hi: Ch, mid: Cv, lo: salt};
            r_list_c     <= '0;
            r_list_p     <= '0;
            r_bitmap     <= '0;
            r_c_cnt      <= '0;
            r_p_cnt      <= '0;
          end
        end
        S_HASH0, S_RHASH_C, S_RHASH_P: begin
          if (hash_done) begin
            r_digest     <= hash_digest;
            r_hash_start <= 1'b0;
            r_state      <= (r_state == S_RHASH_P) ? S_EXT_P : S_EXT_C;
          end
        end
        S_EXT_C: begin
          if (w_c_ok) begin
            r_list_c[r_c_cnt] <= w_chunk;
            r_bitmap[w_chunk] <= 1'b1;
            r_c_cnt           <= r_c_cnt + CNT_W'(1);
          end
          // A full list wins over an exhausted digest in the same cycle
          if (w_c_ok && (r_c_cnt == CNT_W'(TAU - 1))) begin
            r_state      <= S_RHASH_P;
            r_hash_start <= 1'b1;
            r_hash_mode  <= 1'b1;
            r_hash_in    <= rehash_msg(r_digest);
          end else if (w_last) begin
            r_state      <= S_RHASH_C;
            r_hash_start <= 1'b1;
            r_hash_mode  <= 1'b1;
            r_hash_in    <= rehash_msg(r_digest);
          end
        end
        S_EXT_P: begin
          r_list_p[r_p_cnt] <= w_chunk[IDX_P_W-1:0];
          r_p_cnt           <= r_p_cnt + CNT_W'(1);
          if (r_p_cnt == CNT_W'(TAU - 1)) begin
            r_state <= S_DONE;
          end else if (w_last) begin
            r_state      <= S_RHASH_P;
            r_hash_start <= 1'b1;
            r_hash_mode  <= 1'b1;
            r_hash_in    <= rehash_msg(r_digest);
          end
        end
        S_DONE: begin
          r_hcp_end <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign hash_start  = r_hash_start;
  assign hash_mode   = r_hash_mode;
  assign hash_in     = r_hash_in;
  assign challenge_c = r_list_c;
  assign challenge_p = r_list_p;
  assign hcp_end     = r_hcp_end;

endmodule
